// File: rtl/safe_vault_ctrl.sv
// Timed passcode vault: a countdown request opens an entry window; a good code unlocks, bad codes or timeout alarm.
// Latency: outputs are register-decoded, one clk after the sampled event; match is combinational.
// Backpressure: none; request strobes are edge-detected levels and are ignored in states that do not use them.
module safe_vault_ctrl #(
    parameter int                CODE_W     = 16,
    parameter logic [CODE_W-1:0] CODE       = 16'hE469,
    parameter int                TICK_DIV   = 50000000,
    parameter int                WINDOW_SEC = 6,
    parameter int                OPEN_SEC   = 5,
    parameter int                MAX_TRIES  = 3,
    parameter int                SEC_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] passcode,
    input  logic              ct_dn,
    input  logic              enter_psw,
    input  logic              alarm_clr,
    output logic              alarm,
    output logic              unlock,
    output logic              start,
    output logic [SEC_W-1:0]  sec,
    output logic [3:0]        tries_left,
    output logic              match
);

    localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [SEC_W-1:0]   WIN_LAST   = SEC_W'(WINDOW_SEC - 1);
    localparam logic [SEC_W-1:0]   OPEN_LAST  = SEC_W'(OPEN_SEC - 1);
    localparam logic [SEC_W-1:0]   SEC_MAX    = '1;
    localparam logic [3:0]         TRIES_INIT = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WINDOW = 3'd1,
        ST_OPEN   = 3'd2,
        ST_ALARM  = 3'd3
    } state_t;

    state_t             state, state_n;
    logic [PRESC_W-1:0] presc, presc_n;
    logic [SEC_W-1:0]   sec_cnt, sec_n;
    logic [3:0]         tries, tries_n;
    logic               ct_dn_q, enter_q, clr_q;
    logic               ev_ct_dn, ev_enter, ev_clr;
    logic               timed, tick;

    assign match    = (passcode == CODE);
    assign ev_ct_dn = ct_dn & ~ct_dn_q;
    assign ev_enter = enter_psw & ~enter_q;
    assign ev_clr   = alarm_clr & ~clr_q;

    assign timed = (state == ST_WINDOW) || (state == ST_OPEN);
    assign tick  = timed && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            presc   <= '0;
            sec_cnt <= '0;
            tries   <= TRIES_INIT;
            ct_dn_q <= 1'b0;
            enter_q <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state   <= state_n;
            presc   <= presc_n;
            sec_cnt <= sec_n;
            tries   <= tries_n;
            ct_dn_q <= ct_dn;
            enter_q <= enter_psw;
            clr_q   <= alarm_clr;
        end
    end

    always_comb begin
        state_n = state;
        presc_n = '0;
        sec_n   = sec_cnt;
        tries_n = tries;

        case (state)
            ST_IDLE: begin
                if (ev_ct_dn) begin
                    state_n = ST_WINDOW;
                    tries_n = TRIES_INIT;
                end
            end

            ST_WINDOW: begin
                presc_n = tick ? '0 : presc + 1'b1;
                if (tick && (sec_cnt != SEC_MAX)) begin
                    sec_n = sec_cnt + 1'b1;
                end
                if (ev_enter && match) begin
                    state_n = ST_OPEN;
                end else begin
                    if (ev_enter) begin
                        if (tries <= 4'd1) begin
                            tries_n = 4'd0;
                            state_n = ST_ALARM;
                        end else begin
                            tries_n = tries - 4'd1;
                        end
                    end
                    // A non-final wrong try does not mask a timeout in the same cycle.
                    if ((state_n == ST_WINDOW) && tick && (sec_cnt == WIN_LAST)) begin
                        state_n = ST_ALARM;
                    end
                end
            end

            ST_OPEN: begin
                presc_n = tick ? '0 : presc + 1'b1;
                if (tick && (sec_cnt != SEC_MAX)) begin
                    sec_n = sec_cnt + 1'b1;
                end
                if (tick && (sec_cnt == OPEN_LAST)) begin
                    state_n = ST_IDLE;
                end
            end

            ST_ALARM: begin
                if (ev_clr && match) begin
                    state_n = ST_IDLE;
                    tries_n = TRIES_INIT;
                end
            end

            default: begin
                state_n = ST_IDLE;
                tries_n = TRIES_INIT;
            end
        endcase

        // Every state entry restarts the time base.
        if (state_n != state) begin
            presc_n = '0;
            sec_n   = '0;
        end
    end

    assign alarm      = (state == ST_ALARM);
    assign unlock     = (state == ST_OPEN);
    assign start      = (state == ST_WINDOW);
    assign sec        = timed ? sec_cnt : '0;
    assign tries_left = tries;

endmodule
